// File: rtl/adc_xy_fb_writer_if.sv
// Framebuffer write channel: valid/ready handshake carrying one pixel write.
// The master (the writer) drives valid/addr/color; the slave drives ready.
interface adc_xy_fb_writer_if #(
    parameter int ADDR_BITS = 19
);
    logic                 fb_wr_valid;
    logic                 fb_wr_ready;
    logic [ADDR_BITS-1:0] fb_wr_addr;
    logic [2:0]           fb_wr_color;

    modport master (
        output fb_wr_valid,
        output fb_wr_addr,
        output fb_wr_color,
        input  fb_wr_ready
    );

    modport slave (
        input  fb_wr_valid,
        input  fb_wr_addr,
        input  fb_wr_color,
        output fb_wr_ready
    );
endinterface

// File: rtl/adc_xy_fb_writer.sv
// ADC beam sample -> framebuffer pixel write.
// Pipeline: S1 capture, S2 range check + linearise, S3 staging, then a
// first-word-fall-through FIFO towards the framebuffer write channel.
// A sample presented on edge N is visible on fb_wr_valid after edge N+3.
// Optional build macro ADC_XY_FB_DEDUP_EN: skip a push identical to the
// last pushed {addr,color}; history is cleared by reset and by enable=0.
module adc_xy_fb_writer #(
    parameter int DATA_BITS  = 10,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int ADDR_BITS  = 19,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_adc_valid,
    input  logic [DATA_BITS-1:0] i_adc_x,
    input  logic [DATA_BITS-1:0] i_adc_y,
    input  logic                 i_adc_red,
    input  logic                 i_adc_grn,
    input  logic                 i_adc_blu,
    adc_xy_fb_writer_if.master   fb,
    output logic [15:0]          o_dropped_cnt,
    output logic                 o_overflow
);
    localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS   = PTR_BITS + 1;
    localparam int ENTRY_BITS = ADDR_BITS + 3;

    logic                 r_s1_v;
    logic [DATA_BITS-1:0] r_s1_x;
    logic [DATA_BITS-1:0] r_s1_y;
    logic [2:0]           r_s1_rgb;
    logic                 r_s2_v;
    logic [ADDR_BITS-1:0] r_s2_addr;
    logic [2:0]           r_s2_rgb;
    logic                 r_s3_v;
    logic [ADDR_BITS-1:0] r_s3_addr;
    logic [2:0]           r_s3_rgb;

    logic [ENTRY_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   r_wr_ptr;
    logic [PTR_BITS-1:0]   r_rd_ptr;
    logic [CNT_BITS-1:0]   r_count;
    logic [15:0]           r_dropped;
    logic                  r_overflow;

    logic                  w_s1_keep;
    logic [ADDR_BITS-1:0]  w_s1_addr;
    logic [ENTRY_BITS-1:0] w_s3_entry;
    logic [ENTRY_BITS-1:0] w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_dup;
    logic                  w_push;
    logic                  w_drop;

    // Off-screen or blank-beam samples never reach the FIFO.
    assign w_s1_keep = r_s1_v && (int'(r_s1_x) < FB_WIDTH) && (int'(r_s1_y) < FB_HEIGHT)
                       && (r_s1_rgb != 3'b000);
    assign w_s1_addr = ADDR_BITS'(r_s1_y) * ADDR_BITS'(FB_WIDTH) + ADDR_BITS'(r_s1_x);

    // S1: capture the raw ADC sample every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_v   <= 1'b0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_s1_rgb <= '0;
        end else begin
            r_s1_v   <= i_enable & i_adc_valid;
            r_s1_x   <= i_adc_x;
            r_s1_y   <= i_adc_y;
            r_s1_rgb <= {i_adc_red, i_adc_grn, i_adc_blu};
        end
    end

    // S2 qualifies and linearises, S3 stages the candidate push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s2_v    <= 1'b0;
            r_s2_addr <= '0;
            r_s2_rgb  <= '0;
            r_s3_v    <= 1'b0;
            r_s3_addr <= '0;
            r_s3_rgb  <= '0;
        end else begin
            r_s2_v    <= w_s1_keep;
            r_s2_addr <= w_s1_addr;
            r_s2_rgb  <= r_s1_rgb;
            r_s3_v    <= r_s2_v;
            r_s3_addr <= r_s2_addr;
            r_s3_rgb  <= r_s2_rgb;
        end
    end

    assign w_s3_entry = {r_s3_addr, r_s3_rgb};
    assign w_full     = (r_count == CNT_BITS'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_pop      = !w_empty && fb.fb_wr_ready;

`ifdef ADC_XY_FB_DEDUP_EN
    logic                  r_hist_v;
    logic [ENTRY_BITS-1:0] r_hist;

    assign w_dup = r_hist_v && (r_hist == w_s3_entry);

    // History of the last accepted push; enable=0 forgets it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist_v <= 1'b0;
            r_hist   <= '0;
        end else if (!i_enable) begin
            r_hist_v <= 1'b0;
        end else if (w_push) begin
            r_hist_v <= 1'b1;
            r_hist   <= w_s3_entry;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push = r_s3_v && !w_dup && (!w_full || w_pop);
    assign w_drop = r_s3_v && !w_dup && w_full && !w_pop;

    // FIFO storage; contents are qualified by r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_s3_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap since depth is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_BITS'(1);
            else if (w_pop && !w_push) r_count <= r_count - CNT_BITS'(1);
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dropped  <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            if (r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
            r_overflow <= 1'b1;
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign fb.fb_wr_valid = !w_empty;
    assign fb.fb_wr_addr  = w_empty ? '0 : w_head[ENTRY_BITS-1:3];
    assign fb.fb_wr_color = w_empty ? '0 : w_head[2:0];
    assign o_dropped_cnt  = r_dropped;
    assign o_overflow     = r_overflow;
endmodule

// File: tb/tb_adc_xy_fb_writer.sv
// Self-checking bench for adc_xy_fb_writer: directed table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_adc_xy_fb_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       av = 1'b0;
    logic [9:0] ax = '0;
    logic [9:0] ay = '0;
    logic [2:0] rgb = '0;
    logic       ready = 1'b0;
    logic [15:0] dropped;
    logic        ovf;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    adc_xy_fb_writer_if #(.ADDR_BITS(19)) fb_if ();
    assign fb_if.fb_wr_ready = ready;

    adc_xy_fb_writer dut (
        .clk          (clk),
        .reset        (rst),
        .i_enable     (en),
        .i_adc_valid  (av),
        .i_adc_x      (ax),
        .i_adc_y      (ay),
        .i_adc_red    (rgb[2]),
        .i_adc_grn    (rgb[1]),
        .i_adc_blu    (rgb[0]),
        .fb           (fb_if.master),
        .o_dropped_cnt(dropped),
        .o_overflow   (ovf)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        v;
        logic [18:0] addr;
        logic [2:0]  col;
    } ent_t;

    ent_t        pipe [3];
    logic [21:0] mq[$];
    int          m_drop = 0;
    logic        m_ovf = 1'b0;
    logic        m_hv = 1'b0;
    logic [21:0] m_hist = '0;

    logic [21:0] wlog[$];
    int          wstep[$];

    function automatic ent_t qualify();
        ent_t e;
        int   a;
        a      = int'(ay) * 640 + int'(ax);
        e.v    = en && av && (ax < 10'd640) && (ay < 10'd480) && (rgb != 3'b000);
        e.addr = 19'(a);
        e.col  = rgb;
        return e;
    endfunction

    function automatic void model_edge();
        ent_t c;
        logic dup;
        logic pushed;
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            mq.delete();
            m_drop = 0;
            m_ovf  = 1'b0;
            m_hv   = 1'b0;
            return;
        end
        c       = pipe[2];
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = qualify();
        dup     = 1'b0;
`ifdef ADC_XY_FB_DEDUP_EN
        dup = c.v && m_hv && (m_hist == {c.addr, c.col});
`endif
        if (mq.size() != 0 && ready) void'(mq.pop_front());
        pushed = 1'b0;
        if (c.v && !dup) begin
            if (mq.size() < 8) begin
                mq.push_back({c.addr, c.col});
                pushed = 1'b1;
            end else begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1'b1;
            end
        end
        if (!en) m_hv = 1'b0;
        else if (pushed) begin
            m_hv   = 1'b1;
            m_hist = {c.addr, c.col};
        end
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    // One clock: log any handshake, advance the model, compare at negedge.
    task automatic step();
        if (fb_if.fb_wr_valid && ready) begin
            wlog.push_back({fb_if.fb_wr_addr, fb_if.fb_wr_color});
            wstep.push_back(cyc);
        end
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        chk("m_valid", 32'(fb_if.fb_wr_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("m_addr",  32'(fb_if.fb_wr_addr),  32'(mq[0][21:3]));
            chk("m_color", 32'(fb_if.fb_wr_color), 32'(mq[0][2:0]));
        end else begin
            chk("m_addr_idle",  32'(fb_if.fb_wr_addr),  32'd0);
            chk("m_color_idle", 32'(fb_if.fb_wr_color), 32'd0);
        end
        chk("m_dropped",  32'(dropped), 32'(m_drop));
        chk("m_overflow", 32'(ovf),     32'(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        av  = 1'b0;
        step();
        step();
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c);
        av  = 1'b1;
        ax  = x;
        ay  = y;
        rgb = c;
    endtask

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  c;
        logic        wr;
        logic [18:0] addr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int exp_n;
        tbl[0] = '{10'd5,    10'd2,    3'b101, 1'b1, 19'd1285};
        tbl[1] = '{10'd640,  10'd0,    3'b111, 1'b0, 19'd0};
        tbl[2] = '{10'd0,    10'd480,  3'b001, 1'b0, 19'd0};
        tbl[3] = '{10'd10,   10'd10,   3'b000, 1'b0, 19'd0};
        tbl[4] = '{10'd639,  10'd479,  3'b111, 1'b1, 19'd307199};
        tbl[5] = '{10'd0,    10'd0,    3'b001, 1'b1, 19'd0};
        tbl[6] = '{10'd1023, 10'd1023, 3'b111, 1'b0, 19'd0};
        tbl[7] = '{10'd0,    10'd1,    3'b010, 1'b1, 19'd640};
        tbl[8] = '{10'd639,  10'd0,    3'b100, 1'b1, 19'd639};

        for (int i = 0; i < 3; i++) pipe[i] = '0;

        // Reset state
        do_reset();
        chk("rst_valid",   32'(fb_if.fb_wr_valid), 32'd0);
        chk("rst_addr",    32'(fb_if.fb_wr_addr),  32'd0);
        chk("rst_color",   32'(fb_if.fb_wr_color), 32'd0);
        chk("rst_dropped", 32'(dropped),           32'd0);
        chk("rst_ovf",     32'(ovf),               32'd0);

        // Single samples: latency, address, range and blank checks
        ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].x, tbl[i].y, tbl[i].c);
            step();
            av = 1'b0;
            step();
            step();
            chk("tbl_early_valid", 32'(fb_if.fb_wr_valid), 32'd0);
            step();
            chk("tbl_valid", 32'(fb_if.fb_wr_valid), 32'(tbl[i].wr));
            if (tbl[i].wr) begin
                chk("tbl_addr",  32'(fb_if.fb_wr_addr),  32'(tbl[i].addr));
                chk("tbl_color", 32'(fb_if.fb_wr_color), 32'(tbl[i].c));
            end
            step();
            chk("tbl_valid_after", 32'(fb_if.fb_wr_valid), 32'd0);
        end
        chk("tbl_no_drops", 32'(dropped), 32'd0);

        // Overflow: 12 samples into a stalled 8-entry FIFO
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(10'(i + 1), 10'(i), 3'((i % 7) + 1));
            step();
        end
        av = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("ovf_dropped", 32'(dropped), 32'd4);
        chk("ovf_flag",    32'(ovf),     32'd1);
        chk("ovf_head",    32'(fb_if.fb_wr_addr), 32'd1);
        wlog.delete();
        ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("ovf_nwrites", 32'(wlog.size()), 32'd8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            chk("ovf_wr_addr",  32'(wlog[i][21:3]), 32'(641 * i + 1));
            chk("ovf_wr_color", 32'(wlog[i][2:0]),  32'((i % 7) + 1));
        end

        // Full FIFO with simultaneous pop: no drops, one write per clock
        do_reset();
        wlog.delete();
        wstep.delete();
        for (int k = 0; k < 30; k++) begin
            drive(10'(k), 10'd200, 3'b011);
            ready = (k >= 11);
            step();
        end
        av    = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 40; i++) step();
        chk("full_nwrites", 32'(wlog.size()), 32'd30);
        chk("full_dropped", 32'(dropped),     32'd0);
        chk("full_ovf",     32'(ovf),         32'd0);
        if (wlog.size() == 30) begin
            chk("full_rate", 32'(wstep[29] - wstep[0]), 32'd29);
            for (int i = 0; i < 30; i++)
                chk("full_wr_addr", 32'(wlog[i][21:3]), 32'(128000 + i));
        end

        // Reset asserted mid-cycle with 5 queued entries
        do_reset();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(10'(20 + i), 10'd50, 3'b110);
            step();
        end
        av = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rst5_valid_before", 32'(fb_if.fb_wr_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst5_valid_now", 32'(fb_if.fb_wr_valid), 32'd0);
        step();
        rst   = 1'b0;
        ready = 1'b1;
        wlog.delete();
        for (int i = 0; i < 10; i++) step();
        chk("rst5_no_stale", 32'(wlog.size()), 32'd0);

        // Same lit position held for 10 clocks
        do_reset();
        ready = 1'b1;
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            drive(10'd7, 10'd3, 3'b110);
            step();
        end
        av = 1'b0;
        for (int i = 0; i < 10; i++) step();
`ifdef ADC_XY_FB_DEDUP_EN
        exp_n = 1;
`else
        exp_n = 10;
`endif
        chk("hold_nwrites", 32'(wlog.size()), 32'(exp_n));
        for (int i = 0; i < wlog.size(); i++)
            chk("hold_addr", 32'(wlog[i][21:3]), 32'd1927);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 3))
                    0:       ax = 10'($urandom_range(0, 7));
                    1:       ax = 10'($urandom_range(630, 650));
                    default: ax = 10'($urandom_range(0, 1023));
                endcase
                case ($urandom_range(0, 3))
                    0:       ay = 10'($urandom_range(0, 3));
                    1:       ay = 10'($urandom_range(470, 490));
                    default: ay = 10'($urandom_range(0, 1023));
                endcase
                rgb = 3'($urandom_range(0, 7));
                av  = ($urandom_range(0, 3) != 0);
                en  = ($urandom_range(0, 7) != 0);
            end
            if (((k / 60) % 2) == 1) ready = ($urandom_range(0, 3) == 0);
            else                     ready = ($urandom_range(0, 3) != 0);
            step();
        end
        av    = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("rand_drained", 32'(fb_if.fb_wr_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
